// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Optional feature macro: ARB_RR_EN (round-robin between icache and dcache).
package mem_arb_pkg;

    localparam int unsigned DEF_BLOCK_SIZE = 8;

    // Grant encoding on the grant output
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        G_DWR   = 3'd1,
        G_DRD   = 3'd2,
        G_IRD   = 3'd3,
        RELEASE = 3'd4
    } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the icache and dcache requests.
// Ports: i_req, d_wr_req, d_rd_req (request levels), last_grant (only with
// ARB_RR_EN), win (GNT_* encoding), win_wr (dcache winner is the write).
// Macro ARB_RR_EN: round-robin on simultaneous requests; otherwise dcache wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_req,
    input  logic       d_wr_req,
    input  logic       d_rd_req,
`ifdef ARB_RR_EN
    input  logic [1:0] last_grant,
`endif
    output logic [1:0] win,
    output logic       win_wr
);

    logic d_req;

    assign d_req  = d_wr_req | d_rd_req;
    // Within the dcache a pending write-back always goes before its refill
    assign win_wr = d_wr_req;

    always_comb begin
        win = GNT_NONE;
`ifdef ARB_RR_EN
        if (d_req && i_req) begin
            win = (last_grant == GNT_D) ? GNT_I : GNT_D;
        end else if (d_req) begin
            win = GNT_D;
        end else if (i_req) begin
            win = GNT_I;
        end
`else
        if (d_req) begin
            win = GNT_D;
        end else if (i_req) begin
            win = GNT_I;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between icache refills and dcache
// write-back/refill bursts. Grants whole BLOCK_SIZE-beat bursts, routes beat
// strobes to the granted requester only, and keeps a dcache write-back and
// its following refill back to back.
// Ports: clk, reset_n (async active-low); icache read req/addr/data/val;
// dcache write req/addr/data/val and read req/addr/data/val; memory side
// mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_val; grant (00/01/10).
// Macro ARB_RR_EN: round-robin icache/dcache arbitration with last_grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_mem_read_req,
    input  logic [ADDR_W-1:0] i_mem_read_addr,
    output logic [DATA_W-1:0] i_mem_read_data,
    output logic              i_mem_read_val,
    input  logic              d_mem_write_req,
    input  logic [ADDR_W-1:0] d_mem_write_addr,
    input  logic [DATA_W-1:0] d_mem_write_data,
    output logic              d_mem_write_val,
    input  logic              d_mem_read_req,
    input  logic [ADDR_W-1:0] d_mem_read_addr,
    output logic [DATA_W-1:0] d_mem_read_data,
    output logic              d_mem_read_val,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_val,
    output logic [1:0]        grant
);

    localparam int unsigned CNT_W = $clog2(BLOCK_SIZE) + 1;

    arb_state_t        state_q, state_d;
    arb_state_t        src_q, src_d;       // burst type, held through RELEASE
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic              mem_req_d, mem_we_d;
    logic [1:0]        grant_d;
    logic [1:0]        win;
    logic              win_wr;
    logic              src_req;
`ifdef ARB_RR_EN
    logic [1:0]        last_grant_q, last_grant_d;
`endif

    arb_pick u_pick (
        .i_req      (i_mem_read_req),
        .d_wr_req   (d_mem_write_req),
        .d_rd_req   (d_mem_read_req),
`ifdef ARB_RR_EN
        .last_grant (last_grant_q),
`endif
        .win        (win),
        .win_wr     (win_wr)
    );

    // Data paths: write data passes straight through, read data is broadcast
    assign mem_wdata       = d_mem_write_data;
    assign i_mem_read_data = mem_rdata;
    assign d_mem_read_data = mem_rdata;

    // Request level of whoever owned the burst now being released
    always_comb begin
        case (src_q)
            G_DWR:   src_req = d_mem_write_req;
            G_DRD:   src_req = d_mem_read_req;
            G_IRD:   src_req = i_mem_read_req;
            default: src_req = 1'b0;
        endcase
    end

    // Next state, burst bookkeeping and beat strobe routing
    always_comb begin
        state_d         = state_q;
        src_d           = src_q;
        beat_cnt_d      = beat_cnt_q;
        addr_d          = mem_addr;
`ifdef ARB_RR_EN
        last_grant_d    = last_grant_q;
`endif
        i_mem_read_val  = 1'b0;
        d_mem_read_val  = 1'b0;
        d_mem_write_val = 1'b0;

        case (state_q)
            IDLE: begin
                if (win == GNT_I) begin
                    state_d = G_IRD;
                    addr_d  = i_mem_read_addr;
                end else if (win == GNT_D) begin
                    state_d = win_wr ? G_DWR : G_DRD;
                    addr_d  = win_wr ? d_mem_write_addr : d_mem_read_addr;
                end
                if (win != GNT_NONE) begin
                    src_d      = state_d;
                    beat_cnt_d = '0;
`ifdef ARB_RR_EN
                    last_grant_d = win;
`endif
                end
            end

            G_DWR, G_DRD, G_IRD: begin
                i_mem_read_val  = mem_val && (state_q == G_IRD);
                d_mem_read_val  = mem_val && (state_q == G_DRD);
                d_mem_write_val = mem_val && (state_q == G_DWR);
                if (mem_val) begin
                    // Final beat closes the burst; the counter idles at 0
                    if (beat_cnt_q == CNT_W'(BLOCK_SIZE - 1)) begin
                        beat_cnt_d = '0;
                        state_d    = RELEASE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end

            RELEASE: begin
                if (!src_req) begin
                    // Write-back followed by its refill skips arbitration
                    if ((src_q == G_DWR) && d_mem_read_req) begin
                        state_d    = G_DRD;
                        src_d      = G_DRD;
                        addr_d     = d_mem_read_addr;
                        beat_cnt_d = '0;
`ifdef ARB_RR_EN
                        last_grant_d = GNT_D;
`endif
                    end else begin
                        state_d = IDLE;
                        src_d   = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                src_d   = IDLE;
            end
        endcase

        mem_req_d = (state_d == G_DWR) || (state_d == G_DRD) || (state_d == G_IRD);
        mem_we_d  = (state_d == G_DWR);
        grant_d   = (state_d == G_IRD) ? GNT_I : (mem_req_d ? GNT_D : GNT_NONE);
    end

    // State and registered memory-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            src_q        <= IDLE;
            beat_cnt_q   <= '0;
            mem_addr     <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            grant        <= GNT_NONE;
`ifdef ARB_RR_EN
            last_grant_q <= GNT_D;
`endif
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            beat_cnt_q   <= beat_cnt_d;
            mem_addr     <= addr_d;
            mem_req      <= mem_req_d;
            mem_we       <= mem_we_d;
            grant        <= grant_d;
`ifdef ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: cache/memory agents, a reference
// model of the burst order, and a strobe monitor.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned BS = 8;
    localparam logic [31:0] AMASK = 32'hFFFF_FFE0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_mem_read_req;
    logic [31:0] i_mem_read_addr;
    logic [31:0] i_mem_read_data;
    logic        i_mem_read_val;
    logic        d_mem_write_req;
    logic [31:0] d_mem_write_addr;
    logic [31:0] d_mem_write_data;
    logic        d_mem_write_val;
    logic        d_mem_read_req;
    logic [31:0] d_mem_read_addr;
    logic [31:0] d_mem_read_data;
    logic        d_mem_read_val;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_val;
    logic [1:0]  grant;

    mem_port_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_mem_read_req   (i_mem_read_req),
        .i_mem_read_addr  (i_mem_read_addr),
        .i_mem_read_data  (i_mem_read_data),
        .i_mem_read_val   (i_mem_read_val),
        .d_mem_write_req  (d_mem_write_req),
        .d_mem_write_addr (d_mem_write_addr),
        .d_mem_write_data (d_mem_write_data),
        .d_mem_write_val  (d_mem_write_val),
        .d_mem_read_req   (d_mem_read_req),
        .d_mem_read_addr  (d_mem_read_addr),
        .d_mem_read_data  (d_mem_read_data),
        .d_mem_read_val   (d_mem_read_val),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_val          (mem_val),
        .grant            (grant)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  gnt;
        bit          locked;
        bit          first;
    } burst_t;

    typedef struct {
        int          tgt;    // 0 icache read, 1 dcache read, 2 dcache write
        logic [31:0] data;
    } beat_t;

    burst_t      exp_burst[$];
    beat_t       exp_beat[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    logic [31:0] wd[BS];
    logic [31:0] i_addr_r, w_addr_r, r_addr_r;
    int          d_kind_r;   // 1 read, 2 write, 3 write then read
    int          i_issue = 0, i_taken = 0, d_issue = 0, d_taken = 0;
    int          ibeats = 0, dwb = 0, drb = 0;
    bit          beat_this_cyc = 0;
    logic [1:0]  m_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_b(input logic we, input logic [31:0] a, input logic [1:0] g,
                                   input bit locked, input bit first);
        burst_t b;
        b.we = we; b.addr = a; b.gnt = g; b.locked = locked; b.first = first;
        exp_burst.push_back(b);
    endfunction

    // Icache agent: holds its request until all beats of its burst arrive
    initial begin
        i_mem_read_req  = 1'b0;
        i_mem_read_addr = '0;
        forever begin
            @(negedge clk);
            if (i_mem_read_val) ibeats++;
            @(posedge clk); #1;
            if (!reset_n) begin
                i_mem_read_req = 1'b0; ibeats = 0; i_taken = i_issue;
            end else if (i_mem_read_req && ibeats == BS) begin
                i_mem_read_req = 1'b0; ibeats = 0;
            end else if (!i_mem_read_req && i_taken != i_issue) begin
                i_taken++;
                i_mem_read_req  = 1'b1;
                i_mem_read_addr = i_addr_r;
            end
        end
    end

    // Dcache agent: write-back then (optionally) refill raised on the same edge
    initial begin
        d_mem_write_req  = 1'b0;
        d_mem_read_req   = 1'b0;
        d_mem_write_addr = '0;
        d_mem_read_addr  = '0;
        d_mem_write_data = '0;
        forever begin
            @(negedge clk);
            if (d_mem_write_val) dwb++;
            if (d_mem_read_val)  drb++;
            @(posedge clk); #1;
            if (!reset_n) begin
                d_mem_write_req = 1'b0; d_mem_read_req = 1'b0;
                dwb = 0; drb = 0; d_taken = d_issue;
            end else if (d_mem_write_req && dwb == BS) begin
                d_mem_write_req = 1'b0; dwb = 0;
                if (d_kind_r == 3) begin
                    d_mem_read_req  = 1'b1;
                    d_mem_read_addr = r_addr_r;
                end
            end else if (d_mem_read_req && drb == BS) begin
                d_mem_read_req = 1'b0; drb = 0;
            end else if (!d_mem_write_req && !d_mem_read_req && d_taken != d_issue) begin
                d_taken++;
                if (d_kind_r == 1) begin
                    d_mem_read_req  = 1'b1;
                    d_mem_read_addr = r_addr_r;
                end else begin
                    d_mem_write_req  = 1'b1;
                    d_mem_write_addr = w_addr_r;
                end
            end
            d_mem_write_data = (dwb < BS) ? wd[dwb] : 32'h0;
        end
    end

    // Memory agent: random beat timing; records expected strobes and checks bursts
    initial begin : memory
        bit          active;
        int          beats, drop_cyc, tgt;
        burst_t      cur;
        beat_t       bt;
        active = 0; beats = 0; drop_cyc = 0; tgt = 0;
        mem_val = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            beat_this_cyc = 0;
            if (!reset_n) begin
                active = 0; drop_cyc = cyc;
            end else if (mem_req) begin
                if (!active) begin
                    if (exp_burst.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_burst: got addr 0x%08h expected no burst", mem_addr);
                        tgt = 0;
                    end else begin
                        cur = exp_burst.pop_front();
                        check("burst_we",    32'(mem_we),   32'(cur.we));
                        check("burst_addr",  mem_addr,      cur.addr);
                        check("burst_grant", 32'(grant),    32'(cur.gnt));
                        if (cur.first)       check("grant_latency", 32'(cyc), 32'(start_cyc));
                        else if (cur.locked) check("lock_gap", 32'(cyc - drop_cyc), 32'd1);
                        else                 check("burst_gap_ge2", 32'(cyc - drop_cyc >= 2), 32'd1);
                        tgt = (cur.gnt == GNT_I) ? 0 : (cur.we ? 2 : 1);
                    end
                    active = 1; beats = 0;
                end else if (beats == BS) begin
                    check("req_drop_after_last", 32'(mem_req), 32'd0);
                end
            end else if (active) begin
                check("burst_beats", 32'(beats), 32'(BS));
                active = 0; drop_cyc = cyc;
            end
            mem_val   = ($urandom_range(0, 9) < (active ? 6 : 3));
            mem_rdata = $urandom;
            if (reset_n && mem_val && active && beats < BS) begin
                bt.tgt  = tgt;
                bt.data = (tgt == 2) ? wd[beats] : mem_rdata;
                exp_beat.push_back(bt);
                beats++;
                beat_this_cyc = 1;
            end
        end
    end

    // Monitor: pops one expected beat per strobe cycle, else requires silence
    initial begin : monitor
        logic [2:0] stb, e;
        beat_t      b;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                stb = {i_mem_read_val, d_mem_read_val, d_mem_write_val};
                if (beat_this_cyc) begin
                    if (exp_beat.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL beat_queue: got strobes %b expected a queued beat", stb);
                    end else begin
                        b = exp_beat.pop_front();
                        e = 3'b100 >> b.tgt;
                        check("strobe_route", 32'(stb), 32'(e));
                        case (b.tgt)
                            0:       check("i_rdata", i_mem_read_data, b.data);
                            1:       check("d_rdata", d_mem_read_data, b.data);
                            default: check("wdata",   mem_wdata,       b.data);
                        endcase
                    end
                end else if (mem_val) begin
                    check("stray_strobe", 32'(stb), 32'd0);
                end
            end
        end
    end

    // Reference model: burst order from the arbitration and lock rules
    task automatic run_round(input bit i_on, input int dk, input logic [31:0] ia,
                             input logic [31:0] wa, input logic [31:0] ra);
        bit pi, pd, first, take_d, done;
        pi = i_on; pd = (dk != 0); first = 1;
        while (pi || pd) begin
            if (pi && pd) begin
`ifdef ARB_RR_EN
                take_d = (m_last != GNT_D);
`else
                take_d = 1;
`endif
            end else begin
                take_d = pd;
            end
            if (take_d) begin
                if (dk == 1) begin
                    push_b(1'b0, ra, GNT_D, 0, first);
                end else begin
                    push_b(1'b1, wa, GNT_D, 0, first);
                    if (dk == 3) push_b(1'b0, ra, GNT_D, 1, 0);
                end
                pd = 0; m_last = GNT_D;
            end else begin
                push_b(1'b0, ia, GNT_I, 0, first);
                pi = 0; m_last = GNT_I;
            end
            first = 0;
        end
        for (int k = 0; k < BS; k++) wd[k] = $urandom;
        i_addr_r = ia; w_addr_r = wa; r_addr_r = ra; d_kind_r = dk;
        @(negedge clk);
        start_cyc = cyc + 2;
        if (i_on)    i_issue++;
        if (dk != 0) d_issue++;
        done = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (i_taken == i_issue && d_taken == d_issue && !i_mem_read_req &&
                !d_mem_write_req && !d_mem_read_req &&
                exp_burst.size() == 0 && exp_beat.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL round_timeout: got %0d bursts pending expected 0", exp_burst.size());
            exp_burst.delete(); exp_beat.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_mid_burst();
        logic [31:0] ra;
        bit hit;
        ra = $urandom & AMASK;
        push_b(1'b0, ra, GNT_D, 0, 1);
        for (int k = 0; k < BS; k++) wd[k] = $urandom;
        r_addr_r = ra; d_kind_r = 1;
        @(negedge clk);
        start_cyc = cyc + 2;
        d_issue++;
        hit = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #2;
            if (drb >= 4) begin hit = 1; break; end
        end
        if (!hit) begin
            vectors++; miscompares++;
            $display("FAIL reset_wait: got %0d beats expected 4", drb);
        end
        reset_n = 1'b0;
        #1;
        check("rst_mid_mem_req", 32'(mem_req),        32'd0);
        check("rst_mid_grant",   32'(grant),          32'd0);
        check("rst_mid_mem_we",  32'(mem_we),         32'd0);
        check("rst_mid_d_rval",  32'(d_mem_read_val), 32'd0);
        exp_beat.delete(); exp_burst.delete();
        m_last = GNT_D;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b1;
        m_last  = GNT_D;
        #1 reset_n = 1'b0;
        #2;
        check("rst_mem_req",  32'(mem_req),         32'd0);
        check("rst_mem_we",   32'(mem_we),          32'd0);
        check("rst_mem_addr", mem_addr,             32'd0);
        check("rst_grant",    32'(grant),           32'd0);
        check("rst_i_val",    32'(i_mem_read_val),  32'd0);
        check("rst_d_rval",   32'(d_mem_read_val),  32'd0);
        check("rst_d_wval",   32'(d_mem_write_val), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_round(1, 0, 32'h0000_1A00, 32'h0, 32'h0);
        run_round(1, 3, 32'h0000_6A00, 32'h0000_2300, 32'h0000_4300);
        repeat (3) run_round(1, 1, $urandom & AMASK, 32'h0, $urandom & AMASK);
        for (int r = 0; r < 40; r++) begin
            bit i_on;
            int dk;
            i_on = 1'($urandom_range(0, 1));
            dk   = $urandom_range(0, 3);
            if (!i_on && dk == 0) i_on = 1;
            run_round(i_on, dk, $urandom & AMASK, $urandom & AMASK, $urandom & AMASK);
        end
        reset_mid_burst();
        run_round(1, 0, 32'h0000_1A00, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
